autoplay_sequencer: RTL and testbench
=====================================

Name: autoplay_sequencer

Overview:
Consumer side of the song/note memory read interface. On `start` it rewinds the memory read pointer, then fetches stored words one at a time using a read_en / output_ready handshake. Each word is decoded into a note index and a length code, and the note is held on the buzzer/tone driver for the coded duration, followed by a silent articulation gap. Used by the AUTOPLAY and LEARNING modes; sits between the memory unit and the tone generator.

Parameters:
DATA_WIDTH, 8, memory word width; word = {note[DATA_WIDTH-1:LEN_BITS], len[LEN_BITS-1:0]}
LEN_BITS, 3, length-code field width
MAX_DEPTH_BIT, 8, width of song length / note counter
TICK_DIV, 100000, clk cycles per tick (1 ms at 100 MHz)
UNIT_TICKS, 125, ticks per length unit
GAP_TICKS, 20, silent ticks after each note
TIMEOUT, 1024, max clk cycles waiting for mem_ready

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin playback from word 0
stop  in  1  one-cycle pulse; abort playback
pause  in  1  level; freezes timing while high
song_len  in  MAX_DEPTH_BIT  number of words to play (memory duration output)
mem_data  in  DATA_WIDTH  memory data_out
mem_ready  in  1  memory output_ready
read_en  out  1  one-cycle read request to memory
read_rst  out  1  one-cycle read-pointer rewind to memory
note_out  out  DATA_WIDTH-LEN_BITS  current note index (0 = rest)
note_on  out  1  tone generator enable
busy  out  1  high from start accepted until IDLE/DONE
done  out  1  one-cycle pulse on normal completion
timeout_err  out  1  sticky; set on handshake timeout, cleared by next accepted start
played_cnt  out  MAX_DEPTH_BIT  words fully played since start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; all counters 0.
- States: IDLE, REWIND, REQ, WAIT, PLAY, GAP, DONE.
- IDLE, start=1: clear played_cnt and timeout_err. If song_len==0, go to DONE; otherwise go to REWIND.
- REWIND: read_rst=1 for exactly one cycle, then REQ.
- REQ: read_en=1 for exactly one cycle, then WAIT. The wait counter is cleared.
- WAIT: on the first cycle with mem_ready=1, latch mem_data, load the duration counter with (len+1)*UNIT_TICKS, and go to PLAY.
- WAIT timeout: if the wait counter reaches TIMEOUT, set timeout_err and go to IDLE. done is not pulsed.
- End marker: mem_data all ones is the end-of-song marker. Go straight to DONE; played_cnt is not incremented.
- PLAY: note_out = latched note. note_on = (note!=0) & !pause. The duration counter decrements once per tick. When it reaches 0, increment played_cnt and go to GAP.
- GAP: note_on=0 for GAP_TICKS ticks. Then go to DONE if played_cnt==song_len, otherwise REQ.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE and DONE.
- Tick generator: free-running modulo-TICK_DIV prescaler, enabled only in PLAY/GAP. It is cleared on entry to PLAY so the first tick is a full TICK_DIV cycles later. While pause=1, the prescaler and duration counters hold.
- Latency from start to first read_en: 2 cycles (REWIND, then REQ).
- Note duration in clk cycles: (len+1)*UNIT_TICKS*TICK_DIV.
- Simultaneous events:
  - stop has priority over everything. From any state it goes to IDLE next cycle with note_on=0 and read_en=0. It pulses read_rst once (stop in IDLE is a no-op).
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins.
  - pause in REQ/WAIT has no effect; the handshake completes.
- played_cnt saturates at all-ones; it never wraps.
- Reset mid-note: note_on drops asynchronously with rst_n.

Decomposition:
- Shared package/header (alongside the memory parameter header): DATA_WIDTH, LEN_BITS, MAX_DEPTH_BIT, state encodings, end-marker constant.
- One natural sub-module: `tick_prescaler`, with inputs en, clr, pause and a one-cycle tick output. Everything else stays in the top FSM.

Test Plan:
Use TICK_DIV=4, UNIT_TICKS=2, GAP_TICKS=1, TIMEOUT=16. The memory model returns mem_ready 2 cycles after read_en.
1. Basic playback: song_len=2, words 8'h2B, 8'h11, start.
   - read_rst at cycle+1, read_en at cycle+2.
   - note_out=5, note_on high for 32 cycles; gap 4 cycles.
   - note_out=2, note_on high for 16 cycles; gap.
   - done pulse; played_cnt=2.
2. Rest and end marker: words 8'h03, 8'hFF, song_len=5.
   - note_on stays 0 for 32 cycles (rest).
   - Second word: DONE immediately after latch; played_cnt=1.
3. Zero-length song: song_len=0, start → done one cycle after IDLE→DONE; read_en never asserted.
4. Timeout: memory never raises mem_ready → after 16 WAIT cycles timeout_err=1, busy=0, no done pulse. A subsequent start clears timeout_err.
5. Pause: pause=1 for 40 cycles mid-note.
   - note_on=0 while paused.
   - Total note high time after release is still 32 cycles.
6. Stop/start conflicts: stop during PLAY gives note_on=0 and IDLE next cycle, with a single read_rst pulse. start while busy is ignored. start+stop in the same cycle stays IDLE. Reset mid-GAP gives all outputs 0.

Source files
------------

// File: rtl/autoplay_sequencer_pkg.sv
// Shared definitions for the autoplay sequencer.
// Holds the memory word layout (note field above the length-code field),
// the end-of-song marker, and the FSM state encodings. The states are
// plain 3-bit constants so older code that compares raw state values
// keeps working.
package autoplay_sequencer_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int LEN_BITS      = 3;
  localparam int MAX_DEPTH_BIT = 8;
  localparam int NOTE_BITS     = DATA_WIDTH - LEN_BITS;
  localparam int STATE_W       = 3;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // An all-ones word ends the song early.
  localparam word_t END_MARKER = '1;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_REWIND = 3'd1;
  localparam logic [STATE_W-1:0] ST_REQ    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] ST_PLAY   = 3'd4;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

  function automatic logic [NOTE_BITS-1:0] word_note(input word_t w);
    return w[DATA_WIDTH-1:LEN_BITS];
  endfunction

  function automatic logic [LEN_BITS-1:0] word_len(input word_t w);
    return w[LEN_BITS-1:0];
  endfunction

endpackage

// File: rtl/autoplay_sequencer_if.sv
// Song memory read interface between the sequencer (master) and the
// note memory (slave).
//   read_en   master->slave  one-cycle request for the word at the pointer
//   read_rst  master->slave  one-cycle rewind of the read pointer to word 0
//   mem_data  slave->master  word returned for the last request
//   mem_ready slave->master  qualifies mem_data
// Handshake: the master pulses read_en for exactly one cycle and then holds
// off any further request until it sees mem_ready=1 (or gives up after a
// timeout). mem_data is only sampled in a cycle where mem_ready=1; at most
// one request is ever outstanding, and mem_ready outside a pending request
// is ignored.
interface autoplay_sequencer_if;
  import autoplay_sequencer_pkg::*;

  logic  read_en;
  logic  read_rst;
  word_t mem_data;
  logic  mem_ready;

  modport master (output read_en, output read_rst, input mem_data, input mem_ready);
  modport slave  (input read_en, input read_rst, output mem_data, output mem_ready);
endinterface

// File: rtl/autoplay_sequencer_tick_prescaler.sv
// Modulo-TICK_DIV prescaler producing a one-cycle tick.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          count only while high
//   clr         synchronous restart from zero (wins over en)
//   pause       hold the count while high
//   tick        high on the last count of each TICK_DIV period
module tick_prescaler
  import autoplay_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic pause,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tick = en & ~pause & ~clr & (r_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en & ~pause) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/autoplay_sequencer.sv
// Autoplay sequencer: fetches song words from note memory and plays each
// note on the tone generator for its coded length, followed by a silent gap.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse; begin playback from word 0 (only accepted in IDLE)
//   stop         pulse; abort playback (highest priority)
//   pause        level; freezes note timing while high
//   song_len     number of words to play
//   mem          memory read interface (master side)
//   note_out     note index while a note is playing
//   note_on      tone generator enable
//   busy         playback in progress
//   done         one-cycle pulse on normal completion
//   timeout_err  sticky memory-handshake timeout flag
//   played_cnt   words fully played since the last start (saturating)
//   dbg_state    current FSM state
module autoplay_sequencer
  import autoplay_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int UNIT_TICKS = 125,
  parameter int GAP_TICKS  = 20,
  parameter int TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic [MAX_DEPTH_BIT-1:0] song_len,
  autoplay_sequencer_if.master     mem,
  output logic [NOTE_BITS-1:0]     note_out,
  output logic                     note_on,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [MAX_DEPTH_BIT-1:0] played_cnt,
  output logic [STATE_W-1:0]       dbg_state
);
  localparam int DUR_MAX = (1 << LEN_BITS) * UNIT_TICKS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_TICKS + 2);
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  logic [STATE_W-1:0]       r_state;
  logic [NOTE_BITS-1:0]     r_note;
  logic [DUR_W-1:0]         r_dur;
  logic [GAP_W-1:0]         r_gap;
  logic [WAIT_W-1:0]        r_wait;
  logic [MAX_DEPTH_BIT-1:0] r_played;
  logic                     r_timeout_err;
  logic                     r_stop_rst;

  logic w_tick;
  logic w_presc_en;
  logic w_latch;

  assign w_presc_en = (r_state == ST_PLAY) | (r_state == ST_GAP);
  // A real note word is being accepted; restart the prescaler so the first
  // tick of the note lands a full TICK_DIV cycles later.
  assign w_latch = (r_state == ST_WAIT) & mem.mem_ready & ~stop &
                   (mem.mem_data != END_MARKER);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_presc_en),
    .clr   (w_latch),
    .pause (pause),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_note        <= '0;
      r_dur         <= '0;
      r_gap         <= '0;
      r_wait        <= '0;
      r_played      <= '0;
      r_timeout_err <= 1'b0;
      r_stop_rst    <= 1'b0;
    end else begin
      r_stop_rst <= 1'b0;
      if (stop) begin
        // Abort rewinds the memory pointer so the next start is clean.
        if (r_state != ST_IDLE) begin
          r_state    <= ST_IDLE;
          r_stop_rst <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_played      <= '0;
              r_timeout_err <= 1'b0;
              r_state       <= (song_len == '0) ? ST_DONE : ST_REWIND;
            end
          end
          ST_REWIND: r_state <= ST_REQ;
          ST_REQ: begin
            r_wait  <= '0;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (mem.mem_ready) begin
              if (mem.mem_data == END_MARKER) begin
                r_state <= ST_DONE;
              end else begin
                r_note  <= word_note(mem.mem_data);
                r_dur   <= DUR_W'((int'(word_len(mem.mem_data)) + 1) * UNIT_TICKS);
                r_state <= ST_PLAY;
              end
            end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
              r_timeout_err <= 1'b1;
              r_state       <= ST_IDLE;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          ST_PLAY: begin
            // The tick that would bring the counter to zero ends the note.
            if (w_tick) begin
              if (r_dur <= DUR_W'(1)) begin
                r_dur <= '0;
                if (r_played != '1) r_played <= r_played + 1'b1;
                r_gap   <= GAP_W'(GAP_TICKS);
                r_state <= ST_GAP;
              end else begin
                r_dur <= r_dur - 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (w_tick) begin
              if (r_gap <= GAP_W'(1)) begin
                r_gap   <= '0;
                r_state <= (r_played == song_len) ? ST_DONE : ST_REQ;
              end else begin
                r_gap <= r_gap - 1'b1;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Outputs decode from registered state, so they all drop with rst_n.
  assign mem.read_en  = (r_state == ST_REQ);
  assign mem.read_rst = (r_state == ST_REWIND) | r_stop_rst;
  assign note_out     = (r_state == ST_PLAY) ? r_note : '0;
  assign note_on      = (r_state == ST_PLAY) & (r_note != '0) & ~pause;
  assign busy         = (r_state != ST_IDLE) & (r_state != ST_DONE);
  assign done         = (r_state == ST_DONE);
  assign timeout_err  = r_timeout_err;
  assign played_cnt   = r_played;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_autoplay_sequencer.sv
module tb_autoplay_sequencer;
  import autoplay_sequencer_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int UNIT_TICKS = 2;
  localparam int GAP_TICKS  = 1;
  localparam int TIMEOUT    = 16;
  localparam int EW         = 5 + NOTE_BITS;
  localparam int PH_OTHER   = 0;
  localparam int PH_PLAY    = 1;
  localparam int PH_GAP     = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pause = 1'b0;
  logic [MAX_DEPTH_BIT-1:0] song_len = '0;
  logic [NOTE_BITS-1:0]     note_out;
  logic                     note_on, busy, done, timeout_err;
  logic [MAX_DEPTH_BIT-1:0] played_cnt;
  logic [STATE_W-1:0]       dbg_state;

  always #5 clk = ~clk;

  autoplay_sequencer_if mif();

  autoplay_sequencer #(
    .TICK_DIV(TICK_DIV), .UNIT_TICKS(UNIT_TICKS), .GAP_TICKS(GAP_TICKS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .song_len(song_len), .mem(mif), .note_out(note_out), .note_on(note_on),
    .busy(busy), .done(done), .timeout_err(timeout_err), .played_cnt(played_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model: ready 2 cycles after read_en ----------------
  logic [DATA_WIDTH-1:0] song [0:15];
  logic mem_dead = 1'b0;
  logic mem_d1;
  logic [3:0] mem_ptr, mem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ptr <= '0; mem_addr <= '0; mem_d1 <= 1'b0;
      mif.mem_ready <= 1'b0; mif.mem_data <= '0;
    end else begin
      mem_d1 <= mif.read_en;
      if (mif.read_en) begin
        mem_addr <= mem_ptr;
        mem_ptr  <= mem_ptr + 4'd1;
      end
      if (mif.read_rst) mem_ptr <= '0;
      mif.mem_ready <= mem_d1 & ~mem_dead;
      mif.mem_data  <= song[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  bit            pz_q[$];
  int            ph_q[$];
  int            exp_played;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit rr, input bit re, input bit no, input logic [NOTE_BITS-1:0] nt,
                      input bit bz, input bit dn, input bit pz, input int ph);
    exp_q.push_back({rr, re, no, nt, bz, dn});
    pz_q.push_back(pz);
    ph_q.push_back(ph);
  endtask

  task automatic clear_model();
    exp_q.delete(); pz_q.delete(); ph_q.delete();
  endtask

  // Expected per-cycle trace after start, from the playback rules:
  // rewind, then per word {request, 2 wait cycles, note for (len+1)*UNIT*DIV
  // cycles, gap for GAP*DIV cycles}, done, idle. Pause (p_len cycles, starting
  // after p_off running cycles of word p_note) stretches that note.
  task automatic build_model(input int n_len, input int p_note, input int p_off, input int p_len);
    int played, idx, k, pc, dur;
    logic [DATA_WIDTH-1:0] w;
    logic [NOTE_BITS-1:0] nt;
    clear_model();
    played = 0; idx = 0; pc = 0;
    if (n_len == 0) begin
      push(0, 0, 0, '0, 0, 1, 0, PH_OTHER);
    end else begin
      push(1, 0, 0, '0, 1, 0, 0, PH_OTHER);
      while (1) begin
        push(0, 1, 0, '0, 1, 0, 0, PH_OTHER);
        push(0, 0, 0, '0, 1, 0, 0, PH_OTHER);
        push(0, 0, 0, '0, 1, 0, 0, PH_OTHER);
        w = song[idx];
        if (w == 8'hFF) begin
          push(0, 0, 0, '0, 0, 1, 0, PH_OTHER);
          break;
        end
        nt  = w[7:3];
        dur = (int'(w[2:0]) + 1) * UNIT_TICKS * TICK_DIV;
        k = 0;
        while (k < dur) begin
          if (idx == p_note && k == p_off && pc < p_len) begin
            push(0, 0, 0, nt, 1, 0, 1, PH_PLAY);
            pc++;
          end else begin
            push(0, 0, nt != 0, nt, 1, 0, 0, PH_PLAY);
            k++;
          end
        end
        idx++;
        if (played < 255) played++;
        repeat (GAP_TICKS * TICK_DIV) push(0, 0, 0, '0, 1, 0, 0, PH_GAP);
        if (played == n_len) begin
          push(0, 0, 0, '0, 0, 1, 0, PH_OTHER);
          break;
        end
      end
    end
    push(0, 0, 0, '0, 0, 0, 0, PH_OTHER);
    exp_played = played;
  endtask

  // ---------------- driver ----------------
  // Pulses start, then steps ncyc cycles of the trace (all if ncyc<0),
  // optionally re-pulsing start at trace index start_at.
  task automatic run_model(input int ncyc, input int start_at);
    int n;
    logic [EW-1:0] obs;
    logic [NOTE_BITS-1:0] nt_obs;
    n = (ncyc < 0 || ncyc > exp_q.size()) ? exp_q.size() : ncyc;
    @(posedge clk); #1; start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = (i == start_at);
      pause = pz_q[i];
      @(negedge clk);
      nt_obs = (ph_q[i] == PH_PLAY) ? note_out : '0;
      obs = {mif.read_rst, mif.read_en, note_on, nt_obs, busy, done};
      check_eq("trace", obs, exp_q[i]);
    end
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {mif.read_rst, mif.read_en, note_on, note_out, busy, done, timeout_err, played_cnt}, 0);
  endtask

  task automatic reset_mid(input int ph, input string tag);
    int at;
    at = -1;
    for (int i = 0; i < exp_q.size(); i++) if (at < 0 && ph_q[i] == ph) at = i;
    run_model(at + 2, -1);
    if (ph == PH_PLAY) check_eq({tag, "_pre_note_on"}, note_on, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_song(input int n, input logic [DATA_WIDTH-1:0] w0, input logic [DATA_WIDTH-1:0] w1);
    for (int i = 0; i < 16; i++) song[i] = 8'h09;
    song[0] = w0;
    song[1] = w1;
    song_len = MAX_DEPTH_BIT'(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rr_cnt, first_play, sl, p_note, p_off, p_len, st_at;

    for (int i = 0; i < 16; i++) song[i] = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic playback, plus an ignored start during the first note
    load_song(2, 8'h2B, 8'h11);
    build_model(2, -1, 0, 0);
    run_model(-1, 10);
    check_eq("basic_played", played_cnt, exp_played);
    check_eq("basic_terr", timeout_err, 0);

    // 2: rest then end marker
    load_song(5, 8'h03, 8'hFF);
    build_model(5, -1, 0, 0);
    run_model(-1, -1);
    check_eq("endmark_played", played_cnt, exp_played);

    // 3: zero-length song
    load_song(0, 8'h2B, 8'h11);
    build_model(0, -1, 0, 0);
    run_model(-1, -1);
    check_eq("zero_played", played_cnt, 0);

    // 4: timeout, then a fresh start clears the flag
    load_song(3, 8'h2B, 8'h11);
    mem_dead = 1'b1;
    clear_model();
    push(1, 0, 0, '0, 1, 0, 0, PH_OTHER);
    push(0, 1, 0, '0, 1, 0, 0, PH_OTHER);
    repeat (TIMEOUT) push(0, 0, 0, '0, 1, 0, 0, PH_OTHER);
    push(0, 0, 0, '0, 0, 0, 0, PH_OTHER);
    push(0, 0, 0, '0, 0, 0, 0, PH_OTHER);
    run_model(-1, -1);
    check_eq("timeout_err_set", timeout_err, 1);
    mem_dead = 1'b0;
    repeat (3) @(negedge clk);
    load_song(0, 8'h2B, 8'h11);
    build_model(0, -1, 0, 0);
    run_model(-1, -1);
    check_eq("timeout_err_clr", timeout_err, 0);

    // 5: pause for 40 cycles mid-note
    load_song(1, 8'h2B, 8'h11);
    build_model(1, 0, 10, 40);
    run_model(-1, -1);
    check_eq("pause_played", played_cnt, 1);

    // 6a: stop during a note
    load_song(2, 8'h2B, 8'h11);
    build_model(2, -1, 0, 0);
    first_play = -1;
    for (int i = 0; i < exp_q.size(); i++) if (first_play < 0 && ph_q[i] == PH_PLAY) first_play = i;
    run_model(first_play + 5, -1);
    @(posedge clk); #1; stop = 1'b1;
    @(negedge clk); rr_cnt = int'(mif.read_rst);
    @(posedge clk); #1; stop = 1'b0;
    @(negedge clk);
    rr_cnt += int'(mif.read_rst);
    check_eq("stop_note_on", note_on, 0);
    check_eq("stop_read_en", mif.read_en, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_done", done, 0);
    repeat (3) begin @(negedge clk); rr_cnt += int'(mif.read_rst); end
    check_eq("stop_rst_pulses", rr_cnt, 1);

    // 6b: start and stop together in IDLE
    @(posedge clk); #1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    rr_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      rr_cnt += int'(mif.read_rst) + int'(mif.read_en) + int'(busy) + int'(done);
    end
    check_eq("startstop_idle", rr_cnt, 0);

    // 6c: asynchronous reset during a note and during a gap
    load_song(2, 8'h2B, 8'h11);
    build_model(2, -1, 0, 0);
    reset_mid(PH_PLAY, "rst_play");
    build_model(2, -1, 0, 0);
    reset_mid(PH_GAP, "rst_gap");
    @(negedge clk);

    // randomized songs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++)
        song[i] = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 4) == 0) song[$urandom_range(1, 3)] = 8'hFF;
      sl = $urandom_range(1, 4);
      song_len = MAX_DEPTH_BIT'(sl);
      if ($urandom_range(0, 1) == 1) begin
        p_note = $urandom_range(0, sl - 1);
        p_off  = $urandom_range(0, 7);
        p_len  = $urandom_range(1, 20);
      end else begin
        p_note = -1; p_off = 0; p_len = 0;
      end
      build_model(sl, p_note, p_off, p_len);
      st_at = $urandom_range(0, exp_q.size() - 1);
      if (exp_q[st_at][1] != 1'b1) st_at = -1;
      run_model(-1, st_at);
      check_eq("rand_played", played_cnt, exp_played);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
